// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Programmable-modulus up/down counter with enable, synchronous clear,
// parallel load (clamped into range), wrap or saturate behaviour at the
// bounds, and registered carry/borrow pulses. tc is combinational so that a
// chain of stages can ripple their enables within one cycle.
//
// Parameters:
//   WIDTH     count register width (>= 1)
//   MODULUS   count range is 0..MODULUS-1, legal 2..2^WIDTH
//   SATURATE  0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   en          in   count enable
//   up          in   1 = increment, 0 = decrement (used only when en=1)
//   clear       in   synchronous clear of count/carry/borrow
//   load        in   synchronous parallel load
//   load_value  in   [WIDTH-1:0] value for load (clamped to MODULUS-1)
//   count       out  [WIDTH-1:0] registered count
//   carry       out  registered pulse after an up-step taken at MODULUS-1
//   borrow      out  registered pulse after a down-step taken at 0
//   tc          out  combinational terminal-count flag
//   capture     in   (COUNTER_CAPTURE_EN only) snapshot request
//   captured    out  (COUNTER_CAPTURE_EN only) [WIDTH-1:0] snapshot of count
//
// Optional feature macro: COUNTER_CAPTURE_EN
//
// Priority on each edge: reset > clear > load > en.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`ifdef COUNTER_CAPTURE_EN
    input  logic             capture,
    output logic [WIDTH-1:0] captured,
`endif
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             tc
);

    // Upper bound held in WIDTH bits; for MODULUS = 2^WIDTH this is all-ones,
    // so no comparison ever needs a wider intermediate value.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             at_max;
    logic             at_min;

    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == ZERO);

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (clear) begin
            count_d = ZERO;
        end else if (load) begin
            // Out-of-range load values are clamped rather than wrapped.
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    carry_d = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : ZERO;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_min) begin
                    borrow_d = 1'b1;
                    count_d  = (SATURATE != 0) ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= ZERO;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign tc     = en & ((up & at_max) | (~up & at_min));

`ifdef COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] captured_q, captured_d;

    // Snapshot takes the pre-update count; clear deliberately leaves it alone.
    always_comb begin
        captured_d = captured_q;
        if (capture) begin
            captured_d = count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            captured_q <= ZERO;
        end else begin
            captured_q <= captured_d;
        end
    end

    assign captured = captured_q;
`endif

endmodule
